alu_share_arb: RTL and testbench
================================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 3, meaning the number of requesters sharing the ALU (legal range 2..8).
REQ-002 SHALL have parameter SETTLE, default 1, meaning cycles the ALU operand word is held before the result is captured (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester request valid.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester request accept.
REQ-007 SHALL have port req_data  input  NREQ*10  per-requester 10-bit ALU operand/control word; requester i occupies bits [10i+9:10i].
REQ-008 SHALL have port resp_valid  output  NREQ  per-requester result valid.
REQ-009 SHALL have port resp_ready  input  NREQ  per-requester result accept.
REQ-010 SHALL have port resp_data  output  6  result word, shared by all requesters.
REQ-011 SHALL have port alu_in  output  10  operand word driven to the shared combinational ALU (pi0..pi9 order, bit 0 = pi0).
REQ-012 SHALL have port alu_out  input  6  ALU result (po0..po5 order, bit 0 = po0).
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, DRIVE, CAPT, RESP.
REQ-015 In IDLE, SHALL select a winner by round-robin: search indices ptr, ptr+1, ... wrapping modulo NREQ; the first with req_valid high wins.
REQ-016 SHALL assert req_ready only in IDLE, only for the winner, combinationally from state and req_valid; every other req_ready bit SHALL be 0.
REQ-017 A request transfer SHALL occur when req_valid[i] and req_ready[i] are both high; the block SHALL then latch the winner's 10-bit word into the operand register, latch the index into gnt, load the settle counter with SETTLE, and move to DRIVE.
REQ-018 alu_in SHALL equal the operand register in all states; the register SHALL change only on a request transfer.
REQ-019 In DRIVE, SHALL decrement the settle counter each cycle and move to CAPT in the cycle after the counter reaches 1.
REQ-020 In CAPT, SHALL register alu_out into the result register and move to RESP.
REQ-021 In RESP, resp_valid[gnt] SHALL be 1, all other resp_valid bits 0, and resp_data SHALL equal the result register.
REQ-022 In RESP, on resp_ready[gnt] high, SHALL set ptr to (gnt+1) mod NREQ and return to IDLE; resp_ready on any other index SHALL be ignored.
REQ-023 Latency: transfer in cycle T SHALL produce resp_valid in cycle T+SETTLE+2; minimum request-to-request spacing is SETTLE+3 cycles.
REQ-024 A requester dropping req_valid before a transfer SHALL leave the FSM, ptr and all registers unchanged.
REQ-025 While not in IDLE, new requests SHALL be stalled (req_ready all 0) with no loss of any pending req_valid.
REQ-026 resp_data SHALL hold its last value outside RESP; consumers SHALL qualify it with resp_valid.
REQ-027 A requester holding resp_valid unaccepted SHALL block all others indefinitely (no timeout).

Reset
REQ-028 With rst high at a clock edge, SHALL go to IDLE, clear ptr, gnt, the operand register, the result register and the settle counter to 0, regardless of current state.
REQ-029 After reset: req_ready, resp_valid and busy SHALL be 0 (req_ready following REQ-016 from the next cycle), alu_in = 10'h000, resp_data = 6'h00.
REQ-030 Reset mid-transaction SHALL abandon it with no response issued.

Verification
REQ-031 Single request: NREQ=3, SETTLE=1, req_valid=3'b010, req_data[19:10]=10'h2A5, ALU model returns 6'h15 -> req_ready=3'b010 in the same cycle, alu_in=10'h2A5 next cycle, resp_valid=3'b010 with resp_data=6'h15 three cycles after transfer.
REQ-032 Round-robin fairness: all three req_valid held high, resp_ready tied high -> grant order 0,1,2,0,1,2 with a transfer every 4 cycles.
REQ-033 Backpressure: resp_ready[gnt]=0 for 10 cycles -> resp_valid and resp_data stable, req_ready=0 throughout, release on first resp_ready.
REQ-034 SETTLE=4 -> resp_valid asserted exactly 6 cycles after transfer; alu_out changes during DRIVE do not affect the captured value except in the CAPT cycle.
REQ-035 Reset in DRIVE and in RESP -> next cycle busy=0, resp_valid=0, alu_in=0, ptr=0; a subsequent request from index 2 alone is granted normally.
REQ-036 Wrong-index resp_ready (index 0 high while gnt=1) -> no state change.

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin arbiter that time-shares one external combinational ALU among NREQ requesters.
// Each grant drives the operand for SETTLE cycles, captures the result, then holds it until accepted.
module alu_share_arb #(
  parameter int NREQ   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*10-1:0]   req_data,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [5:0]           resp_data,
  output logic [9:0]           alu_in,
  input  logic [5:0]           alu_out,
  output logic                 busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [9:0]      opnd_q, opnd_d;
  logic [5:0]      res_q, res_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [9:0]      sel_word;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IW'(k) == win_idx) sel_word = req_data[k*10 +: 10];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    opnd_d     = opnd_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    resp_valid = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          opnd_d  = sel_word;
          gnt_d   = win_idx;
          cnt_d   = 4'(SETTLE);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = CAPT;
      end
      CAPT: begin
        res_d   = alu_out;
        state_d = RESP;
      end
      RESP: begin
        resp_valid[gnt_q] = 1'b1;
        if (resp_ready[gnt_q]) begin
          ptr_d   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_in    = opnd_q;
  assign resp_data = res_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus a randomized run against a transaction-level model.
module tb_alu_share_arb;

  localparam int S1 = 1;
  localparam int S4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [29:0] req_data;
  logic [5:0]  resp_data, alu_out;
  logic [9:0]  alu_in;
  logic        busy;
  logic        alu_ovr;
  logic [5:0]  alu_const;

  logic [2:0]  req_valid4, req_ready4, resp_valid4, resp_ready4;
  logic [29:0] req_data4;
  logic [5:0]  resp_data4, alu_out4;
  logic [9:0]  alu_in4;
  logic        busy4;
  logic [5:0]  alu4_const;

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [5:0] alu_f(input logic [9:0] x);
    return x[5:0] + {2'b00, x[9:6]};
  endfunction

  assign alu_out  = alu_ovr ? alu_const : alu_f(alu_in);
  assign alu_out4 = alu4_const;

  alu_share_arb #(.NREQ(3), .SETTLE(S1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .alu_in(alu_in), .alu_out(alu_out), .busy(busy)
  );

  alu_share_arb #(.NREQ(3), .SETTLE(S4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_data(req_data4),
    .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_data(resp_data4),
    .alu_in(alu_in4), .alu_out(alu_out4), .busy(busy4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic do_reset;
    tick;
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    sample;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (req_ready !== 3'b000) $display("FAIL reset_req_ready: got %b want 000", req_ready); else n_pass++;
    n_total++; if (resp_valid !== 3'b000) $display("FAIL reset_resp_valid: got %b want 000", resp_valid); else n_pass++;
    n_total++; if (alu_in !== 10'h000) $display("FAIL reset_alu_in: got %h want 000", alu_in); else n_pass++;
    n_total++; if (resp_data !== 6'h00) $display("FAIL reset_resp_data: got %h want 00", resp_data); else n_pass++;
    n_total++; if (busy4 !== 1'b0) $display("FAIL reset_busy4: got %b want 0", busy4); else n_pass++;
  endtask

  task automatic test_single;
    tick;
    alu_ovr = 1'b1;
    alu_const = 6'h15;
    req_data = '0;
    req_data[19:10] = 10'h2A5;
    req_valid = 3'b010;
    sample;
    n_total++; if (req_ready !== 3'b010) $display("FAIL single_req_ready: got %b want 010", req_ready); else n_pass++;
    tick;
    req_valid = 3'b000;
    sample;
    n_total++; if (alu_in !== 10'h2A5) $display("FAIL single_alu_in: got %h want 2a5", alu_in); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    tick;
    sample;
    n_total++; if (resp_valid !== 3'b000) $display("FAIL single_early_resp: got %b want 000", resp_valid); else n_pass++;
    tick;
    resp_ready = 3'b010;
    sample;
    n_total++; if (resp_valid !== 3'b010) $display("FAIL single_resp_valid: got %b want 010", resp_valid); else n_pass++;
    n_total++; if (resp_data !== 6'h15) $display("FAIL single_resp_data: got %h want 15", resp_data); else n_pass++;
    tick;
    resp_ready = 3'b000;
    sample;
    n_total++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else n_pass++;
    n_total++; if (resp_data !== 6'h15) $display("FAIL single_hold_data: got %h want 15", resp_data); else n_pass++;
    alu_ovr = 1'b0;
  endtask

  task automatic test_round_robin;
    int exp_idx;
    int last;
    int ntx;
    int idx;
    int exp_q[$];
    logic [2:0] oh;
    do_reset;
    tick;
    req_data = {10'($urandom), 10'($urandom), 10'($urandom)};
    req_valid = 3'b111;
    resp_ready = 3'b111;
    exp_idx = 0;
    last = 0;
    ntx = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc > 0) tick;
      sample;
      if (req_ready !== 3'b000) begin
        oh = 3'(1 << exp_idx);
        n_total++; if (req_ready !== oh) $display("FAIL rr_grant: cycle %0d got %b want %b", cyc, req_ready, oh); else n_pass++;
        if (ntx > 0) begin
          n_total++; if (cyc - last != 4) $display("FAIL rr_spacing: got %0d want 4", cyc - last); else n_pass++;
        end
        exp_q.push_back(exp_idx);
        last = cyc;
        exp_idx = (exp_idx + 1) % 3;
        ntx++;
      end
      if (resp_valid !== 3'b000) begin
        if (exp_q.size() == 0) begin
          n_total++; $display("FAIL rr_unexpected_resp: got %b want 000", resp_valid);
        end else begin
          idx = exp_q.pop_front();
          oh = 3'(1 << idx);
          n_total++; if (resp_valid !== oh) $display("FAIL rr_resp_valid: got %b want %b", resp_valid, oh); else n_pass++;
          n_total++; if (resp_data !== alu_f(req_data[idx*10 +: 10])) $display("FAIL rr_resp_data: got %h want %h", resp_data, alu_f(req_data[idx*10 +: 10])); else n_pass++;
        end
      end
    end
    n_total++; if (ntx != 6) $display("FAIL rr_count: got %0d want 6", ntx); else n_pass++;
    tick;
    req_valid = 3'b000;
    tick;
    tick;
    resp_ready = 3'b000;
  endtask

  task automatic test_backpressure;
    logic [9:0] d0;
    tick;
    d0 = 10'($urandom);
    req_data[9:0] = d0;
    req_data[29:20] = 10'($urandom);
    req_valid = 3'b101;
    resp_ready = 3'b000;
    sample;
    n_total++; if (req_ready !== 3'b001) $display("FAIL bp_grant: got %b want 001", req_ready); else n_pass++;
    tick;
    req_valid = 3'b100;
    sample;
    n_total++; if (req_ready !== 3'b000) $display("FAIL bp_stall_drive: got %b want 000", req_ready); else n_pass++;
    tick;
    sample;
    n_total++; if (req_ready !== 3'b000) $display("FAIL bp_stall_capt: got %b want 000", req_ready); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      tick;
      resp_ready = 3'($urandom) & 3'b110;
      sample;
      n_total++; if (resp_valid !== 3'b001) $display("FAIL bp_resp_valid: cycle %0d got %b want 001", k, resp_valid); else n_pass++;
      n_total++; if (resp_data !== alu_f(d0)) $display("FAIL bp_resp_data: cycle %0d got %h want %h", k, resp_data, alu_f(d0)); else n_pass++;
      n_total++; if (req_ready !== 3'b000) $display("FAIL bp_req_ready: cycle %0d got %b want 000", k, req_ready); else n_pass++;
    end
    tick;
    resp_ready = 3'b001;
    sample;
    n_total++; if (resp_valid !== 3'b001) $display("FAIL bp_release_hold: got %b want 001", resp_valid); else n_pass++;
    tick;
    resp_ready = 3'b000;
    sample;
    n_total++; if (busy !== 1'b0) $display("FAIL bp_released: got %b want 0", busy); else n_pass++;
    n_total++; if (req_ready !== 3'b100) $display("FAIL bp_pending_kept: got %b want 100", req_ready); else n_pass++;
    tick;
    req_valid = 3'b000;
    resp_ready = 3'b111;
    repeat (4) tick;
    resp_ready = 3'b000;
  endtask

  task automatic test_wrong_index;
    tick;
    req_valid = 3'b010;
    sample;
    n_total++; if (req_ready !== 3'b010) $display("FAIL wi_grant: got %b want 010", req_ready); else n_pass++;
    tick;
    req_valid = 3'b000;
    tick;
    tick;
    resp_ready = 3'b001;
    sample;
    n_total++; if (resp_valid !== 3'b010) $display("FAIL wi_resp: got %b want 010", resp_valid); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick;
      resp_ready = 3'b101;
      sample;
      n_total++; if (resp_valid !== 3'b010) $display("FAIL wi_hold: cycle %0d got %b want 010", k, resp_valid); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL wi_busy: cycle %0d got %b want 1", k, busy); else n_pass++;
    end
    tick;
    resp_ready = 3'b010;
    sample;
    tick;
    resp_ready = 3'b000;
    sample;
    n_total++; if (busy !== 1'b0) $display("FAIL wi_release: got %b want 0", busy); else n_pass++;
    n_total++; if (resp_valid !== 3'b000) $display("FAIL wi_resp_clear: got %b want 000", resp_valid); else n_pass++;
  endtask

  task automatic test_settle4;
    logic [9:0] d;
    tick;
    d = 10'($urandom);
    req_data4 = '0;
    req_data4[9:0] = d;
    req_valid4 = 3'b001;
    alu4_const = 6'h3F;
    sample;
    n_total++; if (req_ready4 !== 3'b001) $display("FAIL s4_grant: got %b want 001", req_ready4); else n_pass++;
    for (int k = 1; k <= 6; k++) begin
      tick;
      req_valid4 = 3'b000;
      alu4_const = (k == 5) ? 6'h2B : 6'($urandom);
      sample;
      if (k == 1) begin
        n_total++; if (alu_in4 !== d) $display("FAIL s4_alu_in: got %h want %h", alu_in4, d); else n_pass++;
      end
      if (k < 6) begin
        n_total++; if (resp_valid4 !== 3'b000) $display("FAIL s4_early_resp: k=%0d got %b want 000", k, resp_valid4); else n_pass++;
        n_total++; if (busy4 !== 1'b1) $display("FAIL s4_busy: k=%0d got %b want 1", k, busy4); else n_pass++;
      end else begin
        n_total++; if (resp_valid4 !== 3'b001) $display("FAIL s4_resp_valid: got %b want 001", resp_valid4); else n_pass++;
        n_total++; if (resp_data4 !== 6'h2B) $display("FAIL s4_resp_data: got %h want 2b", resp_data4); else n_pass++;
      end
    end
    tick;
    resp_ready4 = 3'b001;
    tick;
    resp_ready4 = 3'b000;
    sample;
    n_total++; if (busy4 !== 1'b0) $display("FAIL s4_release: got %b want 0", busy4); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [9:0] d2;
    tick;
    req_data[9:0] = 10'h155;
    req_valid = 3'b001;
    resp_ready = 3'b000;
    sample;
    n_total++; if (req_ready !== 3'b001) $display("FAIL rm_grant0: got %b want 001", req_ready); else n_pass++;
    tick;
    req_valid = 3'b000;
    rst = 1'b1;
    sample;
    n_total++; if (busy !== 1'b1) $display("FAIL rm_in_drive: got %b want 1", busy); else n_pass++;
    tick;
    rst = 1'b0;
    sample;
    n_total++; if (busy !== 1'b0) $display("FAIL rm_drive_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (resp_valid !== 3'b000) $display("FAIL rm_drive_resp: got %b want 000", resp_valid); else n_pass++;
    n_total++; if (alu_in !== 10'h000) $display("FAIL rm_drive_alu_in: got %h want 000", alu_in); else n_pass++;
    n_total++; if (resp_data !== 6'h00) $display("FAIL rm_drive_resp_data: got %h want 00", resp_data); else n_pass++;
    tick;
    d2 = 10'($urandom);
    req_data[29:20] = d2;
    req_valid = 3'b100;
    sample;
    n_total++; if (req_ready !== 3'b100) $display("FAIL rm_grant2: got %b want 100", req_ready); else n_pass++;
    tick;
    req_valid = 3'b000;
    tick;
    tick;
    resp_ready = 3'b100;
    sample;
    n_total++; if (resp_valid !== 3'b100) $display("FAIL rm_resp2: got %b want 100", resp_valid); else n_pass++;
    n_total++; if (resp_data !== alu_f(d2)) $display("FAIL rm_resp2_data: got %h want %h", resp_data, alu_f(d2)); else n_pass++;
    tick;
    resp_ready = 3'b000;
    req_valid = 3'b010;
    sample;
    n_total++; if (req_ready !== 3'b010) $display("FAIL rm_grant1: got %b want 010", req_ready); else n_pass++;
    tick;
    req_valid = 3'b000;
    tick;
    tick;
    sample;
    n_total++; if (resp_valid !== 3'b010) $display("FAIL rm_resp1: got %b want 010", resp_valid); else n_pass++;
    tick;
    rst = 1'b1;
    sample;
    tick;
    rst = 1'b0;
    req_valid = 3'b111;
    sample;
    n_total++; if (busy !== 1'b0) $display("FAIL rm_resp_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (resp_valid !== 3'b000) $display("FAIL rm_resp_valid: got %b want 000", resp_valid); else n_pass++;
    n_total++; if (alu_in !== 10'h000) $display("FAIL rm_resp_alu_in: got %h want 000", alu_in); else n_pass++;
    n_total++; if (req_ready !== 3'b001) $display("FAIL rm_ptr_cleared: got %b want 001", req_ready); else n_pass++;
    tick;
    req_valid = 3'b000;
    resp_ready = 3'b111;
    repeat (4) tick;
    resp_ready = 3'b000;
  endtask

  task automatic test_random;
    logic [2:0] pend;
    logic [2:0] exp_rr, exp_rv;
    logic       m_busy;
    int         m_t, m_ptr, m_gnt, win, idx;
    logic [9:0] m_opnd;
    logic [5:0] m_res;
    do_reset;
    pend = '0;
    m_busy = 1'b0;
    m_t = 0;
    m_ptr = 0;
    m_gnt = 0;
    m_opnd = '0;
    m_res = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[i] = 1'b1;
            req_data[i*10 +: 10] = 10'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      req_valid = pend;
      resp_ready = 3'($urandom);
      sample;
      exp_rr = '0;
      exp_rv = '0;
      win = -1;
      if (!m_busy) begin
        for (int k = 0; k < 3; k++) begin
          idx = (m_ptr + k) % 3;
          if (win < 0 && req_valid[idx]) win = idx;
        end
        if (win >= 0) exp_rr[win] = 1'b1;
      end else if (m_t >= S1 + 2) begin
        exp_rv[m_gnt] = 1'b1;
      end
      n_total++; if (req_ready !== exp_rr) $display("FAIL rand_req_ready: cycle %0d got %b want %b", cyc, req_ready, exp_rr); else n_pass++;
      n_total++; if (resp_valid !== exp_rv) $display("FAIL rand_resp_valid: cycle %0d got %b want %b", cyc, resp_valid, exp_rv); else n_pass++;
      n_total++; if (resp_data !== m_res) $display("FAIL rand_resp_data: cycle %0d got %h want %h", cyc, resp_data, m_res); else n_pass++;
      n_total++; if (alu_in !== m_opnd) $display("FAIL rand_alu_in: cycle %0d got %h want %h", cyc, alu_in, m_opnd); else n_pass++;
      n_total++; if (busy !== m_busy) $display("FAIL rand_busy: cycle %0d got %b want %b", cyc, busy, m_busy); else n_pass++;
      if (!m_busy) begin
        if (win >= 0) begin
          m_busy = 1'b1;
          m_t = 1;
          m_gnt = win;
          m_opnd = req_data[win*10 +: 10];
          pend[win] = 1'b0;
        end
      end else if (m_t >= S1 + 2) begin
        if (resp_ready[m_gnt]) begin
          m_busy = 1'b0;
          m_ptr = (m_gnt + 1) % 3;
        end
      end else begin
        if (m_t == S1 + 1) m_res = alu_f(m_opnd);
        m_t++;
      end
    end
    tick;
    req_valid = 3'b000;
    resp_ready = 3'b111;
    repeat (6) tick;
    resp_ready = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    req_data = '0;
    alu_ovr = 1'b0;
    alu_const = '0;
    req_valid4 = '0;
    resp_ready4 = '0;
    req_data4 = '0;
    alu4_const = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_wrong_index;
    test_settle4;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
